// File: rtl/seq_divider_8bit_pkg.sv
// Shared definitions for the sequential restoring divider.
package seq_divider_8bit_pkg;

    // Default operand/result width.
    localparam int unsigned DefaultWidth = 8;

    // Controller states; the encoding is fixed so external observers can rely on it.
    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StBusy = 2'b01,
        StDone = 2'b10
    } div_state_e;

endpackage

// File: rtl/div_sub_stage.sv
// Trial subtractor: a - b computed as a + ~b + 1. carry_o = 1 means no borrow (a >= b).
module div_sub_stage #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH:0] a_i,
    input  logic [WIDTH:0] b_i,
    output logic [WIDTH:0] diff_o,
    output logic           carry_o
);

    logic [WIDTH+1:0] sum;

    // Single adder with carry-in 1; the extra top bit is the carry-out.
    always_comb begin
        sum     = {1'b0, a_i} + {1'b0, ~b_i} + {{(WIDTH+1){1'b0}}, 1'b1};
        diff_o  = sum[WIDTH:0];
        carry_o = sum[WIDTH+1];
    end

endmodule

// File: rtl/seq_divider_8bit.sv
// Sequential restoring divider: one quotient bit per cycle, registered results.
module seq_divider_8bit
    import seq_divider_8bit_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    div_state_e       state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;      // partial remainder
    logic [WIDTH-1:0] quo_q, quo_d;      // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   trial_a;
    logic [WIDTH:0]   trial_b;
    logic [WIDTH:0]   trial_diff;
    logic             trial_carry;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;
    logic             unused_diff_msb;

    div_sub_stage #(
        .WIDTH (WIDTH)
    ) u_sub (
        .a_i     (trial_a),
        .b_i     (trial_b),
        .diff_o  (trial_diff),
        .carry_o (trial_carry)
    );

    // One shift-subtract step: shift {rem, quo} left, try subtracting the divisor.
    always_comb begin
        trial_a  = {rem_q, quo_q[WIDTH-1]};
        trial_b  = {1'b0, dvsr_q};
        // On success the difference is below the divisor, so its MSB is always zero.
        rem_next = trial_carry ? trial_diff[WIDTH-1:0] : trial_a[WIDTH-1:0];
        quo_next = {quo_q[WIDTH-2:0], trial_carry};
        unused_diff_msb = trial_diff[WIDTH];
    end

    // Next-state logic for the controller and datapath registers.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvsr_d      = dvsr_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    dvsr_d = divisor;
                    rem_d  = '0;
                    quo_d  = dividend;
                    cnt_d  = CntW'(WIDTH);
                    if (divisor == '0) begin
                        // Skip the iteration entirely; results are defined directly.
                        state_d     = StDone;
                        quotient_d  = '1;
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                    end else begin
                        state_d = StBusy;
                    end
                end
            end
            StBusy: begin
                rem_d = rem_next;
                quo_d = quo_next;
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    state_d     = StDone;
                    quotient_d  = quo_next;
                    remainder_d = rem_next;
                    dbz_d       = 1'b0;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvsr_q      <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvsr_q      <= dvsr_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    // Outputs decoded from registered state.
    always_comb begin
        busy        = (state_q == StBusy) || (state_q == StDone);
        done        = (state_q == StDone);
        quotient    = quotient_q;
        remainder   = remainder_q;
        div_by_zero = dbz_q;
    end

endmodule
